// File: rtl/edusoc_data_arbiter_pkg.sv
// Shared definitions for the EduSoC data-port arbiter and its bus timer.
// Holds the data-bus widths, the default error read data, the arbiter state
// encoding, the master (owner) codes and a helper that sizes the bus timer.
package edusoc_data_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [DATA_W-1:0] DEF_ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic MST_0 = 1'b0;
  localparam logic MST_1 = 1'b1;

  // Counter width able to hold `limit`; at least one bit so a disabled timer still elaborates.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/edusoc_bus_timer.sv
// Saturating transaction cycle counter for an EduSoC bus port.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   start_i    transaction granted this cycle; the counter reads 1 in the first busy cycle
//   run_i      transaction in progress; the counter advances and saturates, never wraps
//   expired_o  the count has reached LIMIT while running (never asserted when LIMIT is 0)
module edusoc_bus_timer
  import edusoc_data_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CntW     = cnt_width(LIMIT);
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] LimitVal = CntW'(LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (start_i) begin
      cnt_d = CntW'(1);
    end else if (run_i) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LIMIT != 0) && run_i && (cnt_q == LimitVal);

endmodule

// File: rtl/edusoc_data_arbiter.sv
// Two-master round-robin arbiter for the single EduSoC data port.
// One transaction is granted at a time and held until DATA_VALID or a bus timeout.
// Ports:
//   CPU_CLK, CPU_RES              clock, asynchronous active-high reset
//   M0_*/M1_* (REQ,WE,BE,ADDR,WDATA)  master requests and attributes
//   M0_VALID/M1_VALID, *_RDATA    completion pulse and read data per master
//   DATA_REQ/WE/BE/ADDR/WDATA     forwarded request towards edusoc (0 while idle)
//   DATA_VALID, DATA_RDATA        completion from edusoc
//   BUSY, OWNER                   grant status; OWNER keeps the last grantee
//   TIMEOUT_ERR, TIMEOUT_CLR      sticky timeout flag and its clear
module edusoc_data_arbiter
  import edusoc_data_arbiter_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RES,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [BE_W-1:0]   M0_BE,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  output logic              M0_VALID,
  output logic [DATA_W-1:0] M0_RDATA,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [BE_W-1:0]   M1_BE,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  output logic              M1_VALID,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic              DATA_REQ,
  output logic              DATA_WE,
  output logic [BE_W-1:0]   DATA_BE,
  output logic [ADDR_W-1:0] DATA_ADDR,
  output logic [DATA_W-1:0] DATA_WDATA,
  input  logic              DATA_VALID,
  input  logic [DATA_W-1:0] DATA_RDATA,
  output logic              BUSY,
  output logic              OWNER,
  output logic              TIMEOUT_ERR,
  input  logic              TIMEOUT_CLR
);

  arb_state_e state_q;
  logic       owner_q;
  logic       pri_q;
  logic       err_q;

  logic       busy;
  logic       any_req;
  logic       winner;
  logic       expired;
  logic       timed_out;
  logic       done;
  logic [DATA_W-1:0] cpl_rdata;

  assign busy    = (state_q == ST_BUSY);
  assign any_req = M0_REQ | M1_REQ;
  // Contention goes to the priority pointer; a lone requester always wins.
  assign winner  = (M0_REQ && M1_REQ) ? pri_q : (M1_REQ ? MST_1 : MST_0);

  edusoc_bus_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (CPU_CLK),
    .rst_i    (CPU_RES),
    .start_i  ((state_q == ST_IDLE) && any_req),
    .run_i    (busy),
    .expired_o(expired)
  );

  // A real completion in the timeout cycle takes precedence over the timeout.
  assign timed_out = busy && expired && !DATA_VALID;
  assign done      = busy && (DATA_VALID || expired);
  assign cpl_rdata = DATA_VALID ? DATA_RDATA : ERR_RDATA;

  always_ff @(posedge CPU_CLK or posedge CPU_RES) begin
    if (CPU_RES) begin
      state_q <= ST_IDLE;
      owner_q <= MST_0;
      pri_q   <= MST_0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            pri_q   <= ~winner;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Set wins over a simultaneous clear.
      if (timed_out) begin
        err_q <= 1'b1;
      end else if (TIMEOUT_CLR) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    DATA_REQ   = 1'b0;
    DATA_WE    = 1'b0;
    DATA_BE    = '0;
    DATA_ADDR  = '0;
    DATA_WDATA = '0;
    M0_VALID   = 1'b0;
    M0_RDATA   = '0;
    M1_VALID   = 1'b0;
    M1_RDATA   = '0;
    if (busy) begin
      DATA_REQ = 1'b1;
      if (owner_q == MST_1) begin
        DATA_WE    = M1_WE;
        DATA_BE    = M1_BE;
        DATA_ADDR  = M1_ADDR;
        DATA_WDATA = M1_WDATA;
      end else begin
        DATA_WE    = M0_WE;
        DATA_BE    = M0_BE;
        DATA_ADDR  = M0_ADDR;
        DATA_WDATA = M0_WDATA;
      end
    end
    if (done) begin
      if (owner_q == MST_1) begin
        M1_VALID = 1'b1;
        M1_RDATA = cpl_rdata;
      end else begin
        M0_VALID = 1'b1;
        M0_RDATA = cpl_rdata;
      end
    end
  end

  assign BUSY        = busy;
  assign OWNER       = owner_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_edusoc_data_arbiter.sv
// Self-checking bench for edusoc_data_arbiter with a short bus timeout.
module tb_edusoc_data_arbiter;

  localparam int T = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M0_REQ = 0, M0_WE = 0, M1_REQ = 0, M1_WE = 0;
  logic [3:0]  M0_BE = 0, M1_BE = 0;
  logic [31:0] M0_ADDR = 0, M0_WDATA = 0, M1_ADDR = 0, M1_WDATA = 0;
  logic        M0_VALID, M1_VALID;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic        DATA_REQ, DATA_WE;
  logic [3:0]  DATA_BE;
  logic [31:0] DATA_ADDR, DATA_WDATA;
  logic        DATA_VALID = 0;
  logic [31:0] DATA_RDATA = 0;
  logic        BUSY, OWNER, TIMEOUT_ERR;
  logic        TIMEOUT_CLR = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: round-robin pointer and sticky error flag.
  bit pri_m = 0;
  bit err_m = 0;

  logic        we_s    [2];
  logic [3:0]  be_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];

  always #5 clk = ~clk;

  edusoc_data_arbiter #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CPU_CLK    (clk),
    .CPU_RES    (rst),
    .M0_REQ     (M0_REQ),
    .M0_WE      (M0_WE),
    .M0_BE      (M0_BE),
    .M0_ADDR    (M0_ADDR),
    .M0_WDATA   (M0_WDATA),
    .M0_VALID   (M0_VALID),
    .M0_RDATA   (M0_RDATA),
    .M1_REQ     (M1_REQ),
    .M1_WE      (M1_WE),
    .M1_BE      (M1_BE),
    .M1_ADDR    (M1_ADDR),
    .M1_WDATA   (M1_WDATA),
    .M1_VALID   (M1_VALID),
    .M1_RDATA   (M1_RDATA),
    .DATA_REQ   (DATA_REQ),
    .DATA_WE    (DATA_WE),
    .DATA_BE    (DATA_BE),
    .DATA_ADDR  (DATA_ADDR),
    .DATA_WDATA (DATA_WDATA),
    .DATA_VALID (DATA_VALID),
    .DATA_RDATA (DATA_RDATA),
    .BUSY       (BUSY),
    .OWNER      (OWNER),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .TIMEOUT_CLR(TIMEOUT_CLR)
  );

  task automatic set_attrs(input int idx, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    we_s[idx] = we; be_s[idx] = be; addr_s[idx] = addr; wdata_s[idx] = wdata;
  endtask

  // One arbitrated transaction. lat = BUSY cycle carrying DATA_VALID (1..T), 0 = no answer.
  // clr_last drives TIMEOUT_CLR in the completion cycle.
  task automatic do_txn(input bit r0, input bit r1, input int lat, input logic [31:0] rd,
                        input bit clr_last);
    int          win;
    logic        own;
    bit          tmo;
    bit          fin;
    logic [1:0]  v_exp;
    logic [63:0] rd_exp;
    logic [68:0] bus_exp;
    logic [31:0] r;
    win = (r0 && r1) ? (pri_m ? 1 : 0) : (r1 ? 1 : 0);
    own = (win == 1);
    pri_m = !own;
    bus_exp = {we_s[win], be_s[win], addr_s[win], wdata_s[win]};
    @(negedge clk);
    M0_REQ = r0; M0_WE = we_s[0]; M0_BE = be_s[0]; M0_ADDR = addr_s[0]; M0_WDATA = wdata_s[0];
    M1_REQ = r1; M1_WE = we_s[1]; M1_BE = be_s[1]; M1_ADDR = addr_s[1]; M1_WDATA = wdata_s[1];
    DATA_VALID = 0; TIMEOUT_CLR = 0;
    #1;
    n_checks++;
    if ({DATA_REQ, BUSY} !== 2'b00) begin
      n_fail++; $display("FAIL idle_before_grant: req/busy=%b required 00", {DATA_REQ, BUSY});
    end
    fin = 0; tmo = 0;
    for (int k = 1; k <= T && !fin; k++) begin
      @(negedge clk);
      tmo = (k == T) && (lat != k);
      fin = (k == lat) || tmo;
      DATA_VALID = (k == lat); DATA_RDATA = rd; TIMEOUT_CLR = fin && clr_last;
      #1;
      r      = (k == lat) ? rd : ERR;
      v_exp  = fin ? (own ? 2'b10 : 2'b01) : 2'b00;
      rd_exp = fin ? (own ? {r, 32'h0} : {32'h0, r}) : 64'h0;
      n_checks++;
      if ({DATA_REQ, BUSY, OWNER} !== {2'b11, own}) begin
        n_fail++;
        $display("FAIL grant cyc%0d: req/busy/owner=%b required %b", k,
                 {DATA_REQ, BUSY, OWNER}, {2'b11, own});
      end
      n_checks++;
      if ({DATA_WE, DATA_BE, DATA_ADDR, DATA_WDATA} !== bus_exp) begin
        n_fail++;
        $display("FAIL forward cyc%0d: bus=%h required %h", k,
                 {DATA_WE, DATA_BE, DATA_ADDR, DATA_WDATA}, bus_exp);
      end
      n_checks++;
      if ({M1_VALID, M0_VALID} !== v_exp) begin
        n_fail++;
        $display("FAIL valid cyc%0d: m1/m0=%b required %b", k, {M1_VALID, M0_VALID}, v_exp);
      end
      n_checks++;
      if ({M1_RDATA, M0_RDATA} !== rd_exp) begin
        n_fail++;
        $display("FAIL rdata cyc%0d: m1/m0=%h required %h", k, {M1_RDATA, M0_RDATA}, rd_exp);
      end
      n_checks++;
      if (TIMEOUT_ERR !== err_m) begin
        n_fail++; $display("FAIL err_busy cyc%0d: err=%b required %b", k, TIMEOUT_ERR, err_m);
      end
    end
    @(negedge clk);
    M0_REQ = 0; M1_REQ = 0; DATA_VALID = 0; TIMEOUT_CLR = 0;
    #1;
    if (tmo) err_m = 1;
    else if (clr_last) err_m = 0;
    n_checks++;
    if ({DATA_REQ, BUSY, OWNER} !== {2'b00, own}) begin
      n_fail++;
      $display("FAIL idle_after: req/busy/owner=%b required %b", {DATA_REQ, BUSY, OWNER},
               {2'b00, own});
    end
    n_checks++;
    if ({DATA_WE, DATA_BE, DATA_ADDR, DATA_WDATA, M1_VALID, M0_VALID, M1_RDATA, M0_RDATA}
        !== '0) begin
      n_fail++;
      $display("FAIL idle_zero: bus=%h valid=%b rdata=%h required all 0",
               {DATA_WE, DATA_BE, DATA_ADDR, DATA_WDATA}, {M1_VALID, M0_VALID},
               {M1_RDATA, M0_RDATA});
    end
    n_checks++;
    if (TIMEOUT_ERR !== err_m) begin
      n_fail++; $display("FAIL err_after: err=%b required %b", TIMEOUT_ERR, err_m);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({DATA_REQ, BUSY, OWNER, TIMEOUT_ERR, M0_VALID, M1_VALID} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000000",
                         {DATA_REQ, BUSY, OWNER, TIMEOUT_ERR, M0_VALID, M1_VALID});
    end
    @(negedge clk);
    rst = 0;
    #1;
    n_checks++;
    if ({DATA_REQ, BUSY, OWNER, TIMEOUT_ERR, DATA_ADDR, DATA_WDATA, M0_RDATA, M1_RDATA} !== '0)
    begin
      n_fail++; $display("FAIL reset_release: outputs not all 0 (req=%b busy=%b owner=%b)",
                         DATA_REQ, BUSY, OWNER);
    end
  endtask

  task automatic test_single_read();
    set_attrs(0, 1'b0, 4'hF, 32'h100, 32'h0);
    set_attrs(1, 1'b1, 4'h1, 32'h5550, 32'h1111);
    do_txn(1, 0, 3, 32'h12345678, 0);
  endtask

  task automatic test_write_forwarding();
    set_attrs(0, 1'b0, 4'hC, 32'h3000, 32'h0BAD0BAD);
    set_attrs(1, 1'b1, 4'b0011, 32'h2004, 32'hCAFEF00D);
    do_txn(0, 1, 2, 32'h0, 0);
  endtask

  task automatic test_contention();
    bit exp_own;
    set_attrs(0, 1'b0, 4'hF, 32'hA0, 32'h0);
    set_attrs(1, 1'b0, 4'hF, 32'hB0, 32'h0);
    @(negedge clk);
    M0_REQ = 1; M0_ADDR = addr_s[0]; M1_REQ = 1; M1_ADDR = addr_s[1]; DATA_VALID = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      DATA_VALID = (i % 2 == 0);
      DATA_RDATA = 32'h100 + i;
      #1;
      if (i % 2 == 0) begin
        exp_own = pri_m;
        pri_m = !pri_m;
        n_checks++;
        if ({DATA_REQ, OWNER, M1_VALID, M0_VALID} !== {1'b1, exp_own, exp_own, !exp_own}) begin
          n_fail++;
          $display("FAIL contention_grant%0d: req/owner/v1/v0=%b required %b", i,
                   {DATA_REQ, OWNER, M1_VALID, M0_VALID}, {1'b1, exp_own, exp_own, !exp_own});
        end
      end else begin
        n_checks++;
        if (DATA_REQ !== 1'b0) begin
          n_fail++; $display("FAIL contention_idle%0d: req=%b required 0", i, DATA_REQ);
        end
      end
    end
    @(negedge clk);
    M0_REQ = 0; M1_REQ = 0; DATA_VALID = 0;
    #1;
    n_checks++;
    if (DATA_REQ !== 1'b0) begin
      n_fail++; $display("FAIL contention_end: req=%b required 0", DATA_REQ);
    end
  endtask

  task automatic test_timeout();
    set_attrs(0, 1'b0, 4'hF, 32'h4000, 32'h0);
    do_txn(1, 0, 0, 32'h77777777, 0);
    @(negedge clk);
    TIMEOUT_CLR = 1;
    #1;
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1) begin
      n_fail++; $display("FAIL clr_registered: err=%b required 1", TIMEOUT_ERR);
    end
    @(negedge clk);
    TIMEOUT_CLR = 0;
    #1;
    err_m = 0;
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      n_fail++; $display("FAIL clr_effect: err=%b required 0", TIMEOUT_ERR);
    end
    // Timeout with a clear in the same cycle: the set must survive.
    set_attrs(1, 1'b1, 4'h2, 32'h4004, 32'h55);
    do_txn(0, 1, 0, 32'h0, 1);
    @(negedge clk);
    TIMEOUT_CLR = 1;
    @(negedge clk);
    TIMEOUT_CLR = 0;
    err_m = 0;
  endtask

  task automatic test_timeout_race();
    set_attrs(0, 1'b0, 4'hF, 32'h4100, 32'h0);
    do_txn(1, 0, T, 32'hA5A50001, 0);
  endtask

  task automatic test_random();
    bit r0, r1;
    for (int n = 0; n < 40; n++) begin
      for (int m = 0; m < 2; m++)
        set_attrs(m, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(r0, r1, int'($urandom_range(0, T)), $urandom, ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_reset_mid_txn();
    set_attrs(1, 1'b0, 4'hF, 32'h6000, 32'h0);
    do_txn(0, 1, 0, 32'h0, 0);
    @(negedge clk);
    M0_REQ = 1; M0_ADDR = 32'h6100; M0_WE = 1; M0_WDATA = 32'h12; M0_BE = 4'hF;
    @(negedge clk);
    #1;
    n_checks++;
    if ({DATA_REQ, TIMEOUT_ERR} !== 2'b11) begin
      n_fail++; $display("FAIL mid_before_reset: req/err=%b required 11", {DATA_REQ, TIMEOUT_ERR});
    end
    #2;
    rst = 1; DATA_VALID = 1; DATA_RDATA = 32'h99;
    #1;
    n_checks++;
    if ({DATA_REQ, BUSY, OWNER, TIMEOUT_ERR, M0_VALID, M1_VALID, DATA_WE, DATA_BE, DATA_ADDR,
         DATA_WDATA, M0_RDATA, M1_RDATA} !== '0) begin
      n_fail++; $display("FAIL mid_reset: req=%b busy=%b err=%b v0=%b addr=%h required all 0",
                         DATA_REQ, BUSY, TIMEOUT_ERR, M0_VALID, DATA_ADDR);
    end
    @(negedge clk);
    rst = 0; M0_REQ = 0; DATA_VALID = 0;
    pri_m = 0; err_m = 0;
    set_attrs(0, 1'b0, 4'hF, 32'h7000, 32'h0);
    set_attrs(1, 1'b0, 4'hF, 32'h7100, 32'h0);
    do_txn(1, 1, 1, 32'h13579BDF, 0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_forwarding();
    test_contention();
    test_timeout();
    test_timeout_race();
    test_random();
    test_reset_mid_txn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
